// File: rtl/wtm_boot_loader.sv
`timescale 1ns/1ps
// wtm_boot_loader: copies NUM_BYTES bytes streamed from a FLASH reader into
// asynchronous SRAM (setup / we_n pulse / hold per byte), then releases the
// Z8S180 from reset. Any timeout, overrun or early reader stop is terminal.
module wtm_boot_loader #(
    parameter int NUM_BYTES      = 16,
    parameter int SRAM_BASE_ADDR = 0,
    parameter int ADDR_WIDTH     = 19,
    parameter int WE_PULSE_CLKS  = 2,
    parameter int TIMEOUT_CLKS   = 4096
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  flash_read_en,
    input  logic                  flash_read_active,
    input  logic                  flash_tValid,
    input  logic [7:0]            flash_tData,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_data,
    output logic                  mem_ce_n,
    output logic                  mem_we_n,
    output logic                  cpu_reset_n,
    output logic                  boot_done,
    output logic                  boot_error
);

    localparam int CNT_W = $clog2(NUM_BYTES + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CLKS + 1);
    localparam int PLS_W = $clog2(WE_PULSE_CLKS + 1);

    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(SRAM_BASE_ADDR);
    localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(NUM_BYTES);
    localparam logic [TMR_W-1:0]      TMR_LAST = TMR_W'(TIMEOUT_CLKS - 1);
    localparam logic [PLS_W-1:0]      PLS_LAST = PLS_W'(WE_PULSE_CLKS - 1);

    typedef enum logic [2:0] {
        IDLE, START, WAIT_BYTE, SETUP, PULSE, HOLD, DONE, ERROR
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;   // bytes written to SRAM
    logic [CNT_W-1:0]        rx_cnt_q, rx_cnt_d;       // bytes taken from reader
    logic [7:0]              hold_q, hold_d;
    logic                    full_q, full_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic [PLS_W-1:0]        pls_q, pls_d;
    logic                    fre_q, fre_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              data_q, data_d;
    logic                    ce_n_q, ce_n_d;
    logic                    we_n_q, we_n_d;
    logic                    cpu_rst_n_q, cpu_rst_n_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    capture;
    logic                    overrun;
    logic                    to_error;
    logic [CNT_W:0]          pending;

    // Next-state and next-output logic; every output is the registered copy.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        hold_d      = hold_q;
        full_d      = full_q;
        tmr_d       = tmr_q;
        pls_d       = pls_q;
        fre_d       = fre_q;
        addr_d      = addr_q;
        data_d      = data_q;
        ce_n_d      = ce_n_q;
        we_n_d      = we_n_q;
        cpu_rst_n_d = cpu_rst_n_q;
        done_d      = done_q;
        err_d       = err_q;
        to_error    = 1'b0;

        capture = flash_tValid &&
                  (state_q inside {START, WAIT_BYTE, SETUP, PULSE, HOLD});
        // A second strobe before the byte moved to SRAM would lose data.
        overrun = capture && full_q;
        // Bytes already secured, counting one arriving this very clock.
        pending = {1'b0, byte_cnt_q} + (CNT_W+1)'(full_q) + (CNT_W+1)'(capture);

        if (capture) begin
            hold_d = flash_tData;
            full_d = 1'b1;
            tmr_d  = '0;
            if (rx_cnt_q != LAST_CNT) begin
                rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
            if (rx_cnt_q + CNT_W'(1) == LAST_CNT) begin
                fre_d = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                state_d = START;
                fre_d   = 1'b1;
                tmr_d   = '0;
            end
            START: begin
                if (overrun) begin
                    to_error = 1'b1;
                end else if (flash_read_active) begin
                    state_d = WAIT_BYTE;
                    tmr_d   = '0;
                end else if (!capture) begin
                    if (tmr_q == TMR_LAST) to_error = 1'b1;
                    else                   tmr_d = tmr_q + TMR_W'(1);
                end
            end
            WAIT_BYTE: begin
                if (overrun) begin
                    to_error = 1'b1;
                end else if (full_q) begin
                    state_d = SETUP;
                    full_d  = 1'b0;
                    data_d  = hold_q;
                    addr_d  = BASE + ADDR_WIDTH'(byte_cnt_q);
                    ce_n_d  = 1'b0;
                    we_n_d  = 1'b1;
                end else if (!flash_read_active && pending < {1'b0, LAST_CNT}) begin
                    to_error = 1'b1;
                end else if (!capture) begin
                    if (tmr_q == TMR_LAST) to_error = 1'b1;
                    else                   tmr_d = tmr_q + TMR_W'(1);
                end
            end
            SETUP: begin
                if (overrun) begin
                    to_error = 1'b1;
                end else begin
                    state_d = PULSE;
                    we_n_d  = 1'b0;
                    pls_d   = '0;
                end
            end
            PULSE: begin
                if (overrun) begin
                    to_error = 1'b1;
                end else if (pls_q == PLS_LAST) begin
                    state_d = HOLD;
                    we_n_d  = 1'b1;
                end else begin
                    pls_d = pls_q + PLS_W'(1);
                end
            end
            HOLD: begin
                if (overrun) begin
                    to_error = 1'b1;
                end else begin
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    ce_n_d     = 1'b1;
                    if (byte_cnt_q + CNT_W'(1) == LAST_CNT) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        cpu_rst_n_d = 1'b1;
                        fre_d       = 1'b0;
                    end else begin
                        state_d = WAIT_BYTE;
                        tmr_d   = '0;
                    end
                end
            end
            default: begin
                // DONE and ERROR hold until reset.
            end
        endcase

        if (to_error) begin
            state_d     = ERROR;
            err_d       = 1'b1;
            fre_d       = 1'b0;
            ce_n_d      = 1'b1;
            we_n_d      = 1'b1;
            cpu_rst_n_d = 1'b0;
        end
    end

    // State and output registers; reset also releases a write strobe at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            rx_cnt_q    <= '0;
            hold_q      <= '0;
            full_q      <= 1'b0;
            tmr_q       <= '0;
            pls_q       <= '0;
            fre_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            ce_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            hold_q      <= hold_d;
            full_q      <= full_d;
            tmr_q       <= tmr_d;
            pls_q       <= pls_d;
            fre_q       <= fre_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            ce_n_q      <= ce_n_d;
            we_n_q      <= we_n_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign flash_read_en = fre_q;
    assign mem_addr      = addr_q;
    assign mem_data      = data_q;
    assign mem_ce_n      = ce_n_q;
    assign mem_we_n      = we_n_q;
    assign cpu_reset_n   = cpu_rst_n_q;
    assign boot_done     = done_q;
    assign boot_error    = err_q;

endmodule

// File: tb/tb_wtm_boot_loader.sv
`timescale 1ns/1ps
// Bench for wtm_boot_loader: two instances (16 bytes at base 0, and 4 bytes at
// base 0x7FFFE to exercise address wrap) share one randomized FLASH reader.
// A per-cycle monitor checks each instance against an SRAM/byte-stream model.
module tb_wtm_boot_loader;

    localparam int AW  = 19;
    localparam int NB0 = 16;
    localparam int NB1 = 4;
    localparam int WEP = 2;
    localparam int TO  = 64;
    localparam logic [AW-1:0] BASE0 = 19'h00000;
    localparam logic [AW-1:0] BASE1 = 19'h7FFFE;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic flash_read_active = 1'b0;
    logic flash_tValid = 1'b0;
    logic [7:0] flash_tData = 8'h00;

    logic fre0, ce0, we0, cpu0, done0, err0;
    logic [AW-1:0] addr0;
    logic [7:0] data0;
    logic fre1, ce1, we1, cpu1, done1, err1;
    logic [AW-1:0] addr1;
    logic [7:0] data1;

    always #10 clock = ~clock;

    wtm_boot_loader #(.NUM_BYTES(NB0), .SRAM_BASE_ADDR(0), .ADDR_WIDTH(AW),
                      .WE_PULSE_CLKS(WEP), .TIMEOUT_CLKS(TO)) u_dut (
        .clock(clock), .reset_n(reset_n), .flash_read_en(fre0),
        .flash_read_active(flash_read_active), .flash_tValid(flash_tValid),
        .flash_tData(flash_tData), .mem_addr(addr0), .mem_data(data0),
        .mem_ce_n(ce0), .mem_we_n(we0), .cpu_reset_n(cpu0),
        .boot_done(done0), .boot_error(err0));

    wtm_boot_loader #(.NUM_BYTES(NB1), .SRAM_BASE_ADDR(32'h7FFFE), .ADDR_WIDTH(AW),
                      .WE_PULSE_CLKS(WEP), .TIMEOUT_CLKS(TO)) u_wrap (
        .clock(clock), .reset_n(reset_n), .flash_read_en(fre1),
        .flash_read_active(flash_read_active), .flash_tValid(flash_tValid),
        .flash_tData(flash_tData), .mem_addr(addr1), .mem_data(data1),
        .mem_ce_n(ce1), .mem_we_n(we1), .cpu_reset_n(cpu1),
        .boot_done(done1), .boot_error(err1));

    // ---------------- model state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [7:0] sent[$];          // bytes strobed by the reader since reset
    int cyc = 0;                  // clocks since reset release
    int cap_n = 0;                // strobes the DUTs have been offered
    int wr_cnt[2] = '{0, 0};
    int we_len[2] = '{0, 0};
    int ce_len[2] = '{0, 0};
    int err_at[2] = '{-1, -1};
    logic prev_we[2] = '{1'b1, 1'b1};
    logic prev_ce[2] = '{1'b1, 1'b1};
    logic [AW-1:0] last_addr[2];
    logic [7:0] last_data[2];
    logic [7:0] sram0[int];
    logic [7:0] sram1[int];
    int wrap_addr[4] = '{32'h7FFFE, 32'h7FFFF, 0, 1};

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sget(input int id, input int a);
        if (id == 0) return sram0.exists(a) ? int'(sram0[a]) : -1;
        return sram1.exists(a) ? int'(sram1[a]) : -1;
    endfunction

    task automatic mon(input int id, input int nb, input logic [AW-1:0] base,
                       input logic fre, input logic ce_n, input logic we_n,
                       input logic [AW-1:0] addr, input logic [7:0] data,
                       input logic cpu, input logic done, input logic err);
        string p;
        logic [AW-1:0] ea;
        p = (id == 0) ? "main" : "wrap";
        if (err && err_at[id] < 0) err_at[id] = cyc;
        chk({p, " cpu_reset_n"}, cpu, done);
        chk({p, " done&error"}, done & err, 0);
        if (err) begin
            chk({p, " err outputs"}, {fre, ce_n, we_n}, 3'b011);
        end else begin
            chk({p, " flash_read_en"}, fre, (cyc >= 1 && cap_n < nb));
        end
        if (!we_n) chk({p, " we_n without ce_n"}, ce_n, 0);
        if (!ce_n) begin
            chk({p, " write has byte"}, (wr_cnt[id] < sent.size() && wr_cnt[id] < nb), 1);
            if (wr_cnt[id] < sent.size()) begin
                ea = base + AW'(wr_cnt[id]);
                chk({p, " mem_addr"}, addr, ea);
                chk({p, " mem_data"}, data, sent[wr_cnt[id]]);
            end
            last_addr[id] = addr;
            last_data[id] = data;
        end
        if (!we_n) begin
            we_len[id]++;
        end else if (!prev_we[id]) begin
            chk({p, " we_n pulse len"}, we_len[id], WEP);
            we_len[id] = 0;
        end
        if (!ce_n) begin
            ce_len[id]++;
        end else if (!prev_ce[id]) begin
            chk({p, " ce_n access len"}, ce_len[id], WEP + 2);
            ce_len[id] = 0;
            wr_cnt[id]++;
            if (id == 0) sram0[int'(last_addr[0])] = last_data[0];
            else         sram1[int'(last_addr[1])] = last_data[1];
        end
        prev_we[id] = we_n;
        prev_ce[id] = ce_n;
    endtask

    // Per-cycle compare process, sampling on the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                cyc = 0; cap_n = 0;
                for (int i = 0; i < 2; i++) begin
                    wr_cnt[i] = 0; we_len[i] = 0; ce_len[i] = 0; err_at[i] = -1;
                    prev_we[i] = 1'b1; prev_ce[i] = 1'b1;
                end
                sram0.delete();
                sram1.delete();
            end else begin
                mon(0, NB0, BASE0, fre0, ce0, we0, addr0, data0, cpu0, done0, err0);
                mon(1, NB1, BASE1, fre1, ce1, we1, addr1, data1, cpu1, done1, err1);
                if (flash_tValid) cap_n++;
                cyc++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        reset_n = 1'b0;
        flash_read_active = 1'b0;
        flash_tValid = 1'b0;
        sent.delete();
        repeat (3) @(posedge clock);
        #1;
        chk("reset main", {fre0, addr0, data0, ce0, we0, cpu0, done0, err0},
            {1'b0, 19'd0, 8'd0, 2'b11, 3'b000});
        chk("reset wrap", {fre1, addr1, data1, ce1, we1, cpu1, done1, err1},
            {1'b0, 19'd0, 8'd0, 2'b11, 3'b000});
        reset_n = 1'b1;
    endtask

    task automatic wait_fre(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (fre0) begin ok = 1'b1; break; end
        end
        chk("flash_read_en rises", ok, 1);
    endtask

    task automatic strobe();
        flash_tValid = 1'b1;
        flash_tData = 8'($urandom);
        sent.push_back(flash_tData);
    endtask

    // FLASH reader: ~32 clocks per byte (12.5 MHz SPI vs 50 MHz clock).
    task automatic reader(input int nbytes, input bit drop_at_end);
        bit ok;
        wait_fre(ok);
        if (ok) begin
            repeat ($urandom_range(2, 10)) @(posedge clock);
            #1 flash_read_active = 1'b1;
            for (int b = 0; b < nbytes; b++) begin
                repeat ($urandom_range(30, 34) - 1) @(posedge clock);
                #1 strobe();
                @(posedge clock);
                #1 flash_tValid = 1'b0;
            end
            if (drop_at_end) begin
                repeat (3) @(posedge clock);
                #1 flash_read_active = 1'b0;
            end
        end
    endtask

    task automatic expect_end(input string nm, input int w0, input bit d0, input bit e0,
                              input int w1, input bit d1, input bit e1);
        repeat (12) @(posedge clock);
        #1;
        chk({nm, " main writes"}, wr_cnt[0], w0);
        chk({nm, " main done/err/cpu"}, {done0, err0, cpu0}, {d0, e0, d0});
        chk({nm, " wrap writes"}, wr_cnt[1], w1);
        chk({nm, " wrap done/err/cpu"}, {done1, err1, cpu1}, {d1, e1, d1});
        for (int k = 0; k < w0 && k < sent.size(); k++)
            chk({nm, " main sram"}, sget(0, k), sent[k]);
        for (int k = 0; k < w1 && k < sent.size(); k++)
            chk({nm, " wrap sram"}, sget(1, wrap_addr[k]), sent[k]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit hit;

        // Normal 16-byte boot (and 4-byte wrapped boot on the second instance).
        do_reset();
        reader(16, 1'b1);
        expect_end("normal", 16, 1'b1, 1'b0, 4, 1'b1, 1'b0);

        // Reader never goes active: timeout 64 clocks after START.
        do_reset();
        repeat (80) @(posedge clock);
        #1;
        chk("timeout main clock", err_at[0], 65);
        chk("timeout wrap clock", err_at[1], 65);
        expect_end("timeout", 0, 1'b0, 1'b1, 0, 1'b0, 1'b1);

        // Two back-to-back strobes while the first byte is still held.
        do_reset();
        wait_fre(ok);
        repeat (4) @(posedge clock);
        #1 flash_read_active = 1'b1;
        repeat (5) @(posedge clock);
        #1 strobe();
        @(posedge clock);
        #1 strobe();
        @(posedge clock);
        #1 flash_tValid = 1'b0;
        expect_end("overrun", 0, 1'b0, 1'b1, 0, 1'b0, 1'b1);
        chk("overrun flash_read_en", fre0, 0);

        // Reader stops after 10 bytes.
        do_reset();
        reader(10, 1'b1);
        expect_end("drop", 10, 1'b0, 1'b1, 4, 1'b1, 1'b0);

        // Reset during the write pulse of byte 5, then a full restart.
        do_reset();
        reader(5, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 16 && !hit; i++) begin
            @(negedge clock);
            if (wr_cnt[0] == 4 && we0 == 1'b0) hit = 1'b1;
        end
        chk("pulse of byte 5 reached", hit, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset outputs", {we0, ce0, fre0, cpu0}, 4'b1100);
        do_reset();
        reader(16, 1'b1);
        expect_end("restart", 16, 1'b1, 1'b0, 4, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wtm_boot_loader.md
WTM_BOOT_LOADER -- requirements
Module: wtm_boot_loader

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 16: bytes copied from FLASH to SRAM.
REQ-002 SHALL have parameter SRAM_BASE_ADDR, default 0: first SRAM byte address written.
REQ-003 SHALL have parameter ADDR_WIDTH, default 19: SRAM address width.
REQ-004 SHALL have parameter WE_PULSE_CLKS, default 2: clocks mem_we_n is held low per write (min 1).
REQ-005 SHALL have parameter TIMEOUT_CLKS, default 4096: max clocks waited for reader activity or next byte.
REQ-006 SHALL have port clock  input  1  system clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port flash_read_en  output  1  request to the FLASH reader to start/continue reading.
REQ-009 SHALL have port flash_read_active  input  1  FLASH reader busy transferring.
REQ-010 SHALL have port flash_tValid  input  1  one-clock strobe, flash_tData valid.
REQ-011 SHALL have port flash_tData  input  8  byte read from FLASH.
REQ-012 SHALL have port mem_addr  output  ADDR_WIDTH  SRAM write address.
REQ-013 SHALL have port mem_data  output  8  SRAM write data.
REQ-014 SHALL have port mem_ce_n / mem_we_n  output  1 each  SRAM chip enable / write strobe, active low.
REQ-015 SHALL have port cpu_reset_n  output  1  Z8S180 reset; low until boot completes.
REQ-016 SHALL have ports boot_done / boot_error  output  1 each  sticky status flags.

Function
REQ-017 SHALL implement states IDLE, START, WAIT_BYTE, SETUP, PULSE, HOLD, DONE, ERROR.
REQ-018 IDLE SHALL advance to START one clock after reset release; no other trigger.
REQ-019 START SHALL drive flash_read_en=1 and move to WAIT_BYTE on first clock flash_read_active=1.
REQ-020 flash_read_en SHALL stay 1 from START until the NUM_BYTES-th byte is captured, then 0.
REQ-021 Every flash_tValid=1 clock in START/WAIT_BYTE/SETUP/PULSE/HOLD SHALL load flash_tData into a 1-byte holding register and set its full flag.
REQ-022 flash_tValid while holding register full (not yet consumed by SETUP) SHALL be an overrun: go to ERROR.
REQ-023 WAIT_BYTE with holding register full SHALL go to SETUP, clearing full flag, latching mem_data and mem_addr=SRAM_BASE_ADDR+byte_count.
REQ-024 SETUP SHALL last 1 clock (mem_ce_n=0, mem_we_n=1); PULSE WE_PULSE_CLKS clocks (mem_ce_n=0, mem_we_n=0); HOLD 1 clock (mem_ce_n=0, mem_we_n=1).
REQ-025 mem_addr/mem_data SHALL be stable from SETUP through HOLD.
REQ-026 After HOLD byte_count SHALL increment; if equal to NUM_BYTES go to DONE, else WAIT_BYTE.
REQ-027 byte_count SHALL be $clog2(NUM_BYTES+1) bits; address add SHALL truncate to ADDR_WIDTH (wraps, no error).
REQ-028 Timeout counter SHALL reset on entry to START, each flash_tValid, and each WAIT_BYTE entry; reaching TIMEOUT_CLKS in START or WAIT_BYTE SHALL go to ERROR.
REQ-029 flash_read_active falling to 0 in WAIT_BYTE with byte_count+full < NUM_BYTES SHALL go to ERROR.
REQ-030 DONE SHALL set boot_done=1, cpu_reset_n=1 on the clock of entry; terminal until reset.
REQ-031 ERROR SHALL set boot_error=1, flash_read_en=0, mem_ce_n=1, mem_we_n=1, cpu_reset_n=0; terminal until reset.
REQ-032 Outside SETUP/PULSE/HOLD mem_ce_n and mem_we_n SHALL be 1; all outputs registered.

Reset
REQ-033 reset_n=0 SHALL immediately force state IDLE, flash_read_en=0, mem_addr=0, mem_data=0, mem_ce_n=1, mem_we_n=1, cpu_reset_n=0, boot_done=0, boot_error=0, counters and full flag 0.
REQ-034 reset_n=0 mid-write SHALL deassert mem_we_n asynchronously; a later release SHALL restart from byte 0.

Verification
REQ-035 Normal: reader model returns 16 random bytes at 12.5 MHz SPI -> SRAM model holds them at 0x00000..0x0000F in order, boot_done=1, cpu_reset_n=1, exactly 16 we_n pulses of 2 clocks.
REQ-036 Reader never asserts active, TIMEOUT_CLKS=64 -> boot_error=1 at clock 64 after START, cpu_reset_n=0, no we_n pulse.
REQ-037 Two tValid strobes 1 clock apart while first byte unconsumed -> ERROR, boot_error=1, flash_read_en=0.
REQ-038 active drops after 10 bytes -> ERROR; SRAM holds 10 bytes, boot_done=0.
REQ-039 SRAM_BASE_ADDR=0x7FFFE, NUM_BYTES=4 -> writes at 0x7FFFE, 0x7FFFF, 0x00000, 0x00001; boot_done=1.
REQ-040 reset_n pulsed low during PULSE of byte 5 -> mem_we_n=1 same time step; after release full 16-byte copy repeats from 0x00000 and completes.
